mem_ctrl: RTL and testbench

- Single-port byte-wide RAM controller directly downstream of the MEM stage.
- Arbitrates the one 8-bit RAM port between the MEM stage's byte-serial load/store traffic and instruction fetch.
- Assembles each 32-bit little-endian instruction from four consecutive byte reads.
- The MEM stage has absolute priority; fetch is aborted and restarted around data accesses.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl_fetch_asm.sv | 114 +++++++++++
 rtl/mem_ctrl.sv | 63 ++++++
 tb/tb_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-wide RAM controller.
// Contents: fetch FSM state encoding, default RAM address width, the logic
// true/false constants and the fetch byte-address helper.
package mem_ctrl_pkg;

  localparam int   RAM_AW_DEF = 17;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;

  // F0..F3 issue byte k of the word, F1..F4 capture byte k-1.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_F2   = 3'd3,
    ST_F3   = 3'd4,
    ST_F4   = 3'd5,
    ST_DONE = 3'd6
  } fetch_st_t;

  // Full 32-bit byte address of byte k of a fetch at base. The caller
  // truncates it, so the address wraps at the top of the RAM.
  function automatic logic [31:0] byte_addr(input logic [31:0] base,
                                            input logic [1:0]  k);
    return base + {30'd0, k};
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU-side bundle of the RAM controller (IF fetch + MEM access).
// master: pipeline side (drives requests, receives instruction/read data).
// slave : controller side. Latency/backpressure are defined by mem_ctrl.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // instruction fetch
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_inst_o;
  logic        if_done_o;

  // MEM stage byte access
  logic        mem_req_i;
  logic [31:0] mem_addr_i;
  logic        mem_wr_i;
  logic [7:0]  mem_wdata_i;
  logic [7:0]  mem_rdata_o;

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_inst_o, if_done_o,
    output mem_req_i, mem_addr_i, mem_wr_i, mem_wdata_i,
    input  mem_rdata_o
  );

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_inst_o, if_done_o,
    input  mem_req_i, mem_addr_i, mem_wr_i, mem_wdata_i,
    output mem_rdata_o
  );

endinterface

// File: rtl/mem_ctrl_fetch_asm.sv
// mem_ctrl_fetch_asm: fetch FSM assembling a 32-bit little-endian word from
// four byte reads. Latency: request sampled in IDLE -> done pulse 6 cycles
// later. Backpressure: any MEM request or flush aborts and restarts the fetch.
// Ports: clk/rst; if_req_i/if_addr_i/if_flush_i fetch request; mem_req_i
// port-steal indication; ram_din_i read byte; if_inst_o/if_done_o result;
// fetch_vld_o/fetch_addr_o the byte address the fetch wants on the RAM port.
module mem_ctrl_fetch_asm
  import mem_ctrl_pkg::*;
#(
  parameter int          RAM_AW    = RAM_AW_DEF,
  parameter logic [31:0] BOOT_INST = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  input  logic              mem_req_i,
  input  logic [7:0]        ram_din_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  output logic              fetch_vld_o,
  output logic [RAM_AW-1:0] fetch_addr_o
);

  fetch_st_t   state_q;
  logic [31:0] fa_q;
  logic [7:0]  b0_q, b1_q, b2_q;
  logic [31:0] inst_q;

  logic        start;
  logic        abort;
  logic [1:0]  k;
  logic [31:0] fetch_sum;
  logic [31-RAM_AW:0] unused_fetch_hi;

  assign start = if_req_i & ~mem_req_i & ~if_flush_i;
  // MEM wins the port on a simultaneous flush; either way the fetch restarts.
  assign abort = mem_req_i | if_flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fa_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      inst_q  <= BOOT_INST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fa_q    <= if_addr_i;
            state_q <= ST_F0;
          end
        end
        ST_F0, ST_F1, ST_F2, ST_F3, ST_F4: begin
          if (abort) begin
            // partial bytes are discarded; the restart re-latches the address
            state_q <= ST_IDLE;
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
          end else begin
            case (state_q)
              ST_F0: state_q <= ST_F1;
              ST_F1: begin
                b0_q    <= ram_din_i;
                state_q <= ST_F2;
              end
              ST_F2: begin
                b1_q    <= ram_din_i;
                state_q <= ST_F3;
              end
              ST_F3: begin
                b2_q    <= ram_din_i;
                state_q <= ST_F4;
              end
              default: begin
                // F4: the byte on ram_din_i is b3, the most significant
                inst_q  <= {ram_din_i, b2_q, b1_q, b0_q};
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Byte index currently being issued; only F0..F3 drive the RAM port.
  always_comb begin
    k           = 2'd0;
    fetch_vld_o = FALSE;
    case (state_q)
      ST_F0: begin k = 2'd0; fetch_vld_o = TRUE; end
      ST_F1: begin k = 2'd1; fetch_vld_o = TRUE; end
      ST_F2: begin k = 2'd2; fetch_vld_o = TRUE; end
      ST_F3: begin k = 2'd3; fetch_vld_o = TRUE; end
      default: ;
    endcase
  end

  assign fetch_sum       = byte_addr(fa_q, k);
  assign fetch_addr_o    = fetch_sum[RAM_AW-1:0];
  assign unused_fetch_hi = fetch_sum[31:RAM_AW];

  // A flush in the DONE cycle means the word is stale: suppress the pulse.
  assign if_inst_o = inst_q;
  assign if_done_o = (state_q == ST_DONE) & ~if_flush_i & ~rst;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-wide RAM controller shared by MEM and fetch.
// Latency: MEM path zero added latency; fetch word done 6 cycles after request.
// Backpressure: MEM has absolute priority and aborts any fetch in progress.
// Ports: clk/rst; bus (mem_ctrl_if.slave) carries the IF and MEM stage
// signals; ram_addr_o/ram_wr_o/ram_dout_o drive the RAM, ram_din_i is the
// RAM read byte valid one cycle after its address.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          RAM_AW    = RAM_AW_DEF,
  parameter logic [31:0] BOOT_INST = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  logic              fetch_vld;
  logic [RAM_AW-1:0] fetch_addr;
  logic [31-RAM_AW:0] unused_mem_hi;

  mem_ctrl_fetch_asm #(
    .RAM_AW    (RAM_AW),
    .BOOT_INST (BOOT_INST)
  ) u_fetch (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (bus.if_req_i),
    .if_addr_i    (bus.if_addr_i),
    .if_flush_i   (bus.if_flush_i),
    .mem_req_i    (bus.mem_req_i),
    .ram_din_i    (ram_din_i),
    .if_inst_o    (bus.if_inst_o),
    .if_done_o    (bus.if_done_o),
    .fetch_vld_o  (fetch_vld),
    .fetch_addr_o (fetch_addr)
  );

  // Port mux: reset parks the port, then MEM, then the fetch byte.
  always_comb begin
    ram_addr_o = '0;
    ram_wr_o   = FALSE;
    ram_dout_o = '0;
    if (!rst) begin
      if (bus.mem_req_i) begin
        ram_addr_o = bus.mem_addr_i[RAM_AW-1:0];
        ram_wr_o   = bus.mem_wr_i;
        ram_dout_o = bus.mem_wdata_i;
      end else if (fetch_vld) begin
        ram_addr_o = fetch_addr;
      end
    end
  end

  assign unused_mem_hi   = bus.mem_addr_i[31:RAM_AW];
  // MEM does its own byte sequencing; read data passes straight through.
  assign bus.mem_rdata_o = ram_din_i;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized traffic for mem_ctrl,
// checked every cycle against a transaction-level fetch model and a RAM array.
module tb_mem_ctrl;
  localparam int          AW   = 17;
  localparam logic [31:0] BOOT = 32'h1BAD_B007;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus();
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  mem_ctrl #(.RAM_AW(AW), .BOOT_INST(BOOT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ram_addr_o (ram_addr),
    .ram_wr_o   (ram_wr),
    .ram_dout_o (ram_dout),
    .ram_din_i  (ram_din)
  );

  // Synchronous-read RAM; pokes preload it through the same process.
  logic [7:0]    ram_mem [0:(1<<AW)-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [7:0]    poke_dat = '0;
  always @(posedge clk) begin
    if (poke_en) ram_mem[poke_addr] <= poke_dat;
    else if (ram_wr) ram_mem[ram_addr] <= ram_dout;
    ram_din <= ram_mem[ram_addr];
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] s0, s1, s2, s3;
    s0 = a; s1 = a + 32'd1; s2 = a + 32'd2; s3 = a + 32'd3;
    return {ram_mem[s3[AW-1:0]], ram_mem[s2[AW-1:0]],
            ram_mem[s1[AW-1:0]], ram_mem[s0[AW-1:0]]};
  endfunction

  // Transaction model: a fetch accepted at cycle s (idle, request, no MEM,
  // no flush) owns the port in cycles s+1..s+4 for bytes A..A+3, finishes
  // with a word update at s+5 and a done pulse at s+6, unless MEM or a flush
  // shows up in s+1..s+5, which cancels it.
  bit          chk_en = 1'b0;
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_start = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_inst = BOOT;

  always @(negedge clk) begin : model_chk
    int            ph;
    logic [31:0]   t;
    logic [AW-1:0] e_addr;
    logic          e_wr;
    logic [7:0]    e_dout;
    logic          e_done;
    if (chk_en) begin
      ph = cyc - m_start;
      e_addr = '0; e_wr = 1'b0; e_dout = '0; e_done = 1'b0;
      if (!rst) begin
        if (bus.mem_req_i) begin
          e_addr = bus.mem_addr_i[AW-1:0];
          e_wr   = bus.mem_wr_i;
          e_dout = bus.mem_wdata_i;
        end else if (m_act && ph >= 1 && ph <= 4) begin
          t = m_a + 32'(ph - 1);
          e_addr = t[AW-1:0];
        end
        if (m_act && ph == 6 && !bus.if_flush_i) e_done = 1'b1;
      end
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("ram_wr", 32'(ram_wr), 32'(e_wr));
      check("ram_dout", 32'(ram_dout), 32'(e_dout));
      check("if_done", 32'(bus.if_done_o), 32'(e_done));
      check("if_inst", bus.if_inst_o, m_inst);
      check("mem_rdata", 32'(bus.mem_rdata_o), 32'(ram_din));
      if (rst) begin
        m_act  = 1'b0;
        m_inst = BOOT;
      end else if (m_act) begin
        if (ph <= 5 && (bus.mem_req_i || bus.if_flush_i)) m_act = 1'b0;
        else if (ph == 5) m_inst = ram_word(m_a);
        else if (ph == 6) m_act = 1'b0;
      end else if (bus.if_req_i && !bus.mem_req_i && !bus.if_flush_i) begin
        m_act   = 1'b1;
        m_start = cyc;
        m_a     = bus.if_addr_i;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_dat = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic idle_in();
    bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_addr_i = '0; bus.mem_wr_i = 1'b0;
    bus.mem_wdata_i = '0;
  endtask

  // Cycles from the request cycle until if_done_o is seen; 99 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (bus.if_done_o === 1'b1) break;
    end
    if (bus.if_done_o !== 1'b1) n = 99;
  endtask

  task automatic mem_wr_byte(input logic [31:0] a, input logic [7:0] d);
    bus.mem_req_i = 1'b1; bus.mem_wr_i = 1'b1;
    bus.mem_addr_i = a; bus.mem_wdata_i = d;
    tick();
  endtask

  logic [AW-1:0] wrap_exp [4];
  int n;

  initial begin
    idle_in();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    // preload under reset; also show MEM cannot reach the port during reset
    bus.mem_req_i = 1'b1; bus.mem_wr_i = 1'b1; bus.mem_addr_i = 32'h55;
    bus.mem_wdata_i = 8'h99;
    #1;
    check("rst_wr_forced", 32'(ram_wr), 32'd0);
    check("rst_addr_forced", 32'(ram_addr), 32'd0);
    idle_in();
    poke(17'h0, 8'h13); poke(17'h1, 8'h05); poke(17'h2, 8'hA0); poke(17'h3, 8'h00);
    poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
    poke(17'h10, 8'h80);
    poke(17'h20, 8'hA1); poke(17'h21, 8'hA2); poke(17'h22, 8'hA3); poke(17'h23, 8'hA4);
    poke(17'h40, 8'h93); poke(17'h41, 8'h00); poke(17'h42, 8'h10); poke(17'h43, 8'h00);
    poke(17'h1FFFE, 8'h37); poke(17'h1FFFF, 8'h6F);
    check("reset_inst", bus.if_inst_o, BOOT);
    check("reset_done", 32'(bus.if_done_o), 32'd0);
    rst = 1'b0;
    tick();

    // boot fetch from 0
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0;
    wait_done(n);
    check("boot_latency", n, 6);
    check("boot_inst", bus.if_inst_o, 32'h00A00513);
    idle_in();
    tick();

    // MEM store steals the port while the fetch is in F2
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    tick(); tick(); tick();
    mem_wr_byte(32'h200, 8'hEF);
    mem_wr_byte(32'h201, 8'hBE);
    mem_wr_byte(32'h202, 8'hAD);
    mem_wr_byte(32'h203, 8'hDE);
    bus.mem_req_i = 1'b0; bus.mem_wr_i = 1'b0;
    wait_done(n);
    check("memprio_latency", n, 6);
    check("memprio_inst", bus.if_inst_o, 32'h44332211);
    check("memprio_store", {ram_mem[17'h203], ram_mem[17'h202], ram_mem[17'h201], ram_mem[17'h200]},
          32'hDEADBEEF);
    idle_in();
    tick();

    // load passthrough, upper address bits ignored
    bus.mem_req_i = 1'b1; bus.mem_addr_i = 32'hFFFE_0010;
    #1;
    check("load_addr", 32'(ram_addr), 32'h10);
    tick();
    check("load_rdata", 32'(bus.mem_rdata_o), 32'h80);
    idle_in();
    tick();

    // flush in F3 redirects to 0x40
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    tick(); tick(); tick(); tick();
    bus.if_flush_i = 1'b1; bus.if_addr_i = 32'h40;
    tick();
    bus.if_flush_i = 1'b0;
    wait_done(n);
    check("flush_latency", n + 1, 7);
    check("flush_inst", bus.if_inst_o, 32'h00100093);
    idle_in();
    tick();

    // flush during the DONE cycle suppresses the pulse
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    tick(); tick(); tick(); tick(); tick(); tick();
    bus.if_flush_i = 1'b1; bus.if_req_i = 1'b0;
    #1;
    check("done_flush_gated", 32'(bus.if_done_o), 32'd0);
    tick();
    idle_in();
    tick();

    // address wrap at the top of the RAM
    wrap_exp[0] = 17'h1FFFE; wrap_exp[1] = 17'h1FFFF;
    wrap_exp[2] = 17'h00000; wrap_exp[3] = 17'h00001;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1FFFE;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wrap_addr", 32'(ram_addr), 32'(wrap_exp[k]));
    end
    wait_done(n);
    check("wrap_latency", n, 2);
    check("wrap_inst", bus.if_inst_o, 32'h05136F37);
    idle_in();
    tick();

    // reset in F2
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    tick(); tick(); tick();
    rst = 1'b1; bus.if_req_i = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_inst", bus.if_inst_o, BOOT);
    check("midrst_done", 32'(bus.if_done_o), 32'd0);
    check("midrst_addr", 32'(ram_addr), 32'd0);
    tick();

    // randomized mix of fetch, MEM traffic, flushes and resets
    for (int i = 0; i < 600; i++) begin
      bus.if_req_i = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: bus.if_addr_i = 32'($urandom_range(0, 63));
        1: bus.if_addr_i = 32'h1FFFC + 32'($urandom_range(0, 3));
        default: bus.if_addr_i = $urandom;
      endcase
      bus.if_flush_i  = ($urandom_range(0, 15) == 0);
      bus.mem_req_i   = ($urandom_range(0, 7) == 0);
      bus.mem_wr_i    = $urandom_range(0, 1) == 1;
      bus.mem_addr_i  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom;
      bus.mem_wdata_i = 8'($urandom);
      rst             = ($urandom_range(0, 127) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
